// File: rtl/p32_pipelined_subtractor.sv
// rtl/p32_pipelined_subtractor.sv - 3-stage pipelined 32-bit subtractor on a radix-4 prefix carry tree
// Computes a + ~b + 1 with valid/ready flow control and borrow/zero/neg/ovf flags.
module p32_pipelined_subtractor #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    logic adv;

    logic             s1_v_q, s2_v_q, s3_v_q;
    logic [WIDTH-1:0] s1_g_q, s1_p_q, s1_x_q;
    logic             s1_a31_q, s1_b31_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic [WIDTH-1:0] s2_g_d, s2_p_d;
    logic [WIDTH-1:0] s2_g_q, s2_p_q, s2_x_q;
    logic             s2_a31_q, s2_b31_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic [WIDTH-1:0] s3_diff_d;
    logic             s3_borrow_d, s3_zero_d, s3_neg_d, s3_ovf_d;
    logic [WIDTH-1:0] s3_diff_q;
    logic             s3_borrow_q, s3_zero_q, s3_neg_q, s3_ovf_q;
    logic [TAG_W-1:0] s3_tag_q;

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign adv      = ~s3_v_q | out_ready;
    assign in_ready = adv;

    // The carry-in of 1 becomes the bit -1 generate, absorbed into the bit 0 node.
    logic [WIDTH-1:0] g0c, l1_g, l1_p;
    assign g0c = {s1_g_q[WIDTH-1:1], s1_g_q[0] | s1_p_q[0]};

    assign l1_g[0] = g0c[0];
    assign l1_p[0] = s1_p_q[0];
    for (genvar i = 1; i < WIDTH; i++) begin : g_l1
        assign l1_g[i] = g0c[i] | (s1_p_q[i] & g0c[i-1]);
        assign l1_p[i] = s1_p_q[i] & s1_p_q[i-1];
    end

    // Pads below bit 0 act as identity nodes (G = 0, P = 1).
    logic [WIDTH+5:0] l1_gx, l1_px;
    assign l1_gx = {l1_g, 6'b000000};
    assign l1_px = {l1_p, 6'b111111};
    for (genvar i = 0; i < WIDTH; i++) begin : g_l2
        assign s2_g_d[i] = l1_gx[i+6] | (l1_px[i+6] & (l1_gx[i+4] | (l1_px[i+4] &
                           (l1_gx[i+2] | (l1_px[i+2] & l1_gx[i])))));
        assign s2_p_d[i] = l1_px[i+6] & l1_px[i+4] & l1_px[i+2] & l1_px[i];
    end

    logic [WIDTH+23:0] l3_gx;
    logic [WIDTH+15:0] l3_px;
    logic [WIDTH-1:0]  carry;
    assign l3_gx = {s2_g_q, 24'h000000};
    assign l3_px = {s2_p_q, 16'hFFFF};
    for (genvar i = 0; i < WIDTH; i++) begin : g_l3
        assign carry[i] = l3_gx[i+24] | (l3_px[i+16] & (l3_gx[i+16] | (l3_px[i+8] &
                          (l3_gx[i+8] | (l3_px[i] & l3_gx[i])))));
    end

    always_comb begin
        s3_diff_d   = s2_x_q ^ {carry[WIDTH-2:0], 1'b1};
        s3_borrow_d = ~carry[WIDTH-1];
        s3_zero_d   = (s3_diff_d == '0);
        s3_neg_d    = s3_diff_d[WIDTH-1];
        s3_ovf_d    = (s2_a31_q != s2_b31_q) && (s3_diff_d[WIDTH-1] != s2_a31_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_g_q      <= '0;
            s1_p_q      <= '0;
            s1_x_q      <= '0;
            s1_a31_q    <= 1'b0;
            s1_b31_q    <= 1'b0;
            s1_tag_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_g_q      <= '0;
            s2_p_q      <= '0;
            s2_x_q      <= '0;
            s2_a31_q    <= 1'b0;
            s2_b31_q    <= 1'b0;
            s2_tag_q    <= '0;
            s3_v_q      <= 1'b0;
            s3_diff_q   <= '0;
            s3_borrow_q <= 1'b0;
            s3_zero_q   <= 1'b0;
            s3_neg_q    <= 1'b0;
            s3_ovf_q    <= 1'b0;
            s3_tag_q    <= '0;
        end else if (adv) begin
            s1_v_q      <= in_valid;
            s1_g_q      <= a & ~b;
            s1_p_q      <= a | ~b;
            s1_x_q      <= a ^ ~b;
            s1_a31_q    <= a[WIDTH-1];
            s1_b31_q    <= b[WIDTH-1];
            s1_tag_q    <= in_tag;
            s2_v_q      <= s1_v_q;
            s2_g_q      <= s2_g_d;
            s2_p_q      <= s2_p_d;
            s2_x_q      <= s1_x_q;
            s2_a31_q    <= s1_a31_q;
            s2_b31_q    <= s1_b31_q;
            s2_tag_q    <= s1_tag_q;
            s3_v_q      <= s2_v_q;
            s3_diff_q   <= s3_diff_d;
            s3_borrow_q <= s3_borrow_d;
            s3_zero_q   <= s3_zero_d;
            s3_neg_q    <= s3_neg_d;
            s3_ovf_q    <= s3_ovf_d;
            s3_tag_q    <= s2_tag_q;
        end
    end

    assign out_valid = s3_v_q;
    assign diff      = s3_diff_q;
    assign borrow    = s3_borrow_q;
    assign zero      = s3_zero_q;
    assign neg       = s3_neg_q;
    assign ovf       = s3_ovf_q;
    assign out_tag   = s3_tag_q;

endmodule

// File: tb/tb_p32_pipelined_subtractor.sv
// tb/tb_p32_pipelined_subtractor.sv - scoreboard bench for p32_pipelined_subtractor
module tb_p32_pipelined_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] diff;
    logic        borrow, zero, neg, ovf;
    logic [3:0]  out_tag;

    p32_pipelined_subtractor #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .zero(zero), .neg(neg), .ovf(ovf),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] diff;
        logic [3:0]  flags;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    bit   chk_lat = 1'b0;
    logic last_ov;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                   input logic [3:0] it, input int acc);
        exp_t        e;
        logic [32:0] w;
        w       = {1'b0, ia} - {1'b0, ib};
        e.diff  = w[31:0];
        e.flags = {w[32], (w[31:0] == 32'h0), w[31], (ia[31] != ib[31]) && (w[31] != ia[31])};
        e.tag   = it;
        e.acc   = acc;
        return e;
    endfunction

    // Drives one cycle; handshakes seen here are the ones taken at the next rising edge.
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [3:0] it, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; in_tag = it; out_ready = ordy;
        #1;
        last_ov = out_valid;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("diff", diff, e.diff);
                check("flags_bznv", {28'd0, borrow, zero, neg, ovf}, {28'd0, e.flags});
                check("tag", {28'd0, out_tag}, {28'd0, e.tag});
                if (chk_lat) check("latency", edge_cnt - e.acc, 32'd3);
            end
        end
        if (in_valid && in_ready) sb.push_back(model(ia, ib, it, edge_cnt));
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() > 0; n++) step(1'b0, '0, '0, '0, 1'b1);
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_diff", diff, 32'd0);
        check("rst_flags_tag", {24'd0, borrow, zero, neg, ovf, out_tag}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic op with explicit latency observation
        chk_lat = 1'b1;
        step(1'b1, 32'h0000000A, 32'h00000003, 4'h1, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1);
        check("lat_edge1_invalid", {31'd0, last_ov}, 32'd0);
        step(1'b0, '0, '0, '0, 1'b1);
        check("lat_edge2_invalid", {31'd0, last_ov}, 32'd0);
        step(1'b0, '0, '0, '0, 1'b1);
        check("lat_edge3_valid", {31'd0, last_ov}, 32'd1);

        // Boundary vectors
        step(1'b1, 32'h00000000, 32'h00000001, 4'h2, 1'b1);
        step(1'b1, 32'h12345678, 32'h12345678, 4'h3, 1'b1);
        step(1'b1, 32'h80000000, 32'h00000001, 4'h4, 1'b1);
        step(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 4'h5, 1'b1);
        step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h6, 1'b1);
        step(1'b1, 32'h00000000, 32'h80000000, 4'h7, 1'b1);
        drain();

        // Back-to-back stream, then a 5-cycle consumer stall
        for (int t = 0; t < 8; t++)
            step(1'b1, 32'h1000 * (t + 1), 32'h0777 + t, t[3:0], 1'b1);
        chk_lat = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step(1'b1, 32'hDEAD0000 + s, 32'h1, 4'(8 + s), 1'b0);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            if (sb.size() > 0) begin
                check("stall_diff_hold", diff, sb[0].diff);
                check("stall_tag_hold", {28'd0, out_tag}, {28'd0, sb[0].tag});
            end else begin
                check("stall_sb_nonempty", 32'd0, 32'd1);
            end
        end
        drain();

        // Reset with three operations in flight
        step(1'b1, 32'h55, 32'h11, 4'hA, 1'b1);
        step(1'b1, 32'h66, 32'h22, 4'hB, 1'b1);
        step(1'b1, 32'h77, 32'h33, 4'hC, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_diff", diff, 32'd0);
        check("midrst_flags_tag", {24'd0, borrow, zero, neg, ovf, out_tag}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk_lat = 1'b1;
        step(1'b1, 32'h00000100, 32'h00000001, 4'hE, 1'b1);
        for (int n = 0; n < 3; n++) step(1'b0, '0, '0, '0, 1'b1);
        check("post_rst_drained", sb.size(), 32'd0);
        chk_lat = 1'b0;

        // Random traffic with random back-pressure
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            step($urandom_range(0, 3) != 0, ra, rb, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
